// File: rtl/key_event_ctrl.sv
// Keypad front end: synchronise and debounce nine active-low keys, latch presses
// as pending events and deliver them highest-key-first over a valid/ready handshake.
module key_event_ctrl #(
  parameter int unsigned DEB_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [8:0] key_n,
  input  logic       clr,
  input  logic       code_ready,
  output logic       code_valid,
  output logic [3:0] key_code,
  output logic [8:0] pend,
  output logic       overflow
);

  localparam int unsigned N_KEYS = 9;
  localparam int unsigned CODE_W = 4;
  localparam int unsigned CNT_W  = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } state_t;

  logic [N_KEYS-1:0] r_sync1;
  logic [N_KEYS-1:0] r_sync2;
  logic [N_KEYS-1:0] r_deb;
  logic [CNT_W-1:0]  r_cnt [N_KEYS];

  logic [N_KEYS-1:0] w_deb_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt [N_KEYS];
  logic [N_KEYS-1:0] w_press;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CODE_W-1:0] r_sel;
  logic [CODE_W-1:0] w_sel_nxt;
  logic              r_valid;
  logic              w_valid_nxt;
  logic [CODE_W-1:0] r_code;
  logic [CODE_W-1:0] w_code_nxt;
  logic [N_KEYS-1:0] r_pend;
  logic [N_KEYS-1:0] w_pend_nxt;
  logic              r_overflow;
  logic              w_overflow_nxt;
  logic [N_KEYS-1:0] w_consume;
  logic [CODE_W-1:0] w_hi_idx;

  // Two-flop synchroniser and debounce state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
      r_deb   <= '1;
      for (int i = 0; i < N_KEYS; i++) r_cnt[i] <= '0;
    end else begin
      r_sync1 <= key_n;
      r_sync2 <= r_sync1;
      r_deb   <= w_deb_nxt;
      for (int i = 0; i < N_KEYS; i++) r_cnt[i] <= w_cnt_nxt[i];
    end
  end

  // A level must disagree with the debounced state for DEB_CYCLES cycles to take effect
  always_comb begin
    w_deb_nxt = r_deb;
    w_press   = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      w_cnt_nxt[i] = '0;
      if (r_sync2[i] != r_deb[i]) begin
        if (r_cnt[i] == CNT_LAST) begin
          w_deb_nxt[i] = r_sync2[i];
          w_press[i]   = r_deb[i];
        end else begin
          w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    w_hi_idx = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      if (r_pend[i]) w_hi_idx = CODE_W'(i);
    end
  end

  // Event FSM state and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_sel      <= '0;
      r_valid    <= 1'b0;
      r_code     <= '0;
      r_pend     <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_sel      <= w_sel_nxt;
      r_valid    <= w_valid_nxt;
      r_code     <= w_code_nxt;
      r_pend     <= w_pend_nxt;
      r_overflow <= w_overflow_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_sel_nxt      = r_sel;
    w_valid_nxt    = r_valid;
    w_code_nxt     = r_code;
    w_consume      = '0;
    w_pend_nxt     = r_pend;
    w_overflow_nxt = r_overflow;

    case (r_state)
      ST_IDLE: begin
        w_valid_nxt = 1'b0;
        if (|r_pend) begin
          w_sel_nxt   = w_hi_idx;
          w_code_nxt  = w_hi_idx + CODE_W'(1);
          w_valid_nxt = 1'b1;
          w_state_nxt = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        w_valid_nxt = 1'b1;
        if (code_ready) begin
          w_consume   = N_KEYS'(1) << r_sel;
          w_valid_nxt = 1'b0;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // A press on the consuming edge re-arms the flag instead of overflowing
    w_pend_nxt     = (r_pend & ~w_consume) | w_press;
    w_overflow_nxt = r_overflow | (|(w_press & r_pend & ~w_consume));

    if (clr) begin
      w_pend_nxt     = '0;
      w_overflow_nxt = 1'b0;
      w_valid_nxt    = 1'b0;
      w_state_nxt    = ST_IDLE;
    end
  end

  assign code_valid = r_valid;
  assign key_code   = r_code;
  assign pend       = r_pend;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_key_event_ctrl.sv
// Bench for key_event_ctrl: window-based event model compared every cycle, plus
// directed scenarios with literal expectations.
module tb_key_event_ctrl;

  localparam int DEB = 4;

  logic       clk;
  logic       rst;
  logic [8:0] key_n;
  logic       clr;
  logic       code_ready;
  logic       code_valid;
  logic [3:0] key_code;
  logic [8:0] pend;
  logic       overflow;

  int n_checks;
  int n_fail;
  bit cmp_en;

  key_event_ctrl #(.DEB_CYCLES(DEB)) dut (
    .clk        (clk),
    .rst        (rst),
    .key_n      (key_n),
    .clr        (clr),
    .code_ready (code_ready),
    .code_valid (code_valid),
    .key_code   (key_code),
    .pend       (pend),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: the debounced level flips once the last DEB synchronised samples all disagree with it
  logic [8:0] m_hist [0:DEB];
  logic [8:0] m_d;
  logic [8:0] m_pend;
  logic       m_ovf;
  logic       m_valid;
  logic [3:0] m_code;

  always @(posedge clk or posedge rst) begin
    logic [8:0] press;
    logic [8:0] consume;
    logic [8:0] old_pend;
    logic       all_diff;
    if (rst) begin
      for (int t = 0; t <= DEB; t++) m_hist[t] = 9'h1FF;
      m_d = 9'h1FF; m_pend = '0; m_ovf = 1'b0; m_valid = 1'b0; m_code = '0;
    end else begin
      press = '0;
      for (int k = 0; k < 9; k++) begin
        all_diff = 1'b1;
        for (int t = 1; t <= DEB; t++) if (m_hist[t][k] == m_d[k]) all_diff = 1'b0;
        if (all_diff) begin
          press[k] = m_d[k];
          m_d[k]   = ~m_d[k];
        end
      end
      for (int t = DEB; t > 0; t--) m_hist[t] = m_hist[t-1];
      m_hist[0] = key_n;

      consume = '0;
      if (m_valid && code_ready) consume[int'(m_code) - 1] = 1'b1;
      old_pend = m_pend;
      if ((press & m_pend & ~consume) != 0) m_ovf = 1'b1;
      m_pend = (m_pend & ~consume) | press;
      if (m_valid) begin
        if (code_ready) m_valid = 1'b0;
      end else if (old_pend != 0) begin
        for (int k = 0; k < 9; k++) if (old_pend[k]) m_code = 4'(k + 1);
        m_valid = 1'b1;
      end
      if (clr) begin
        m_pend = '0; m_ovf = 1'b0; m_valid = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_valid", 32'(code_valid), 32'(m_valid));
      check("model_code",  32'(key_code),   32'(m_code));
      check("model_pend",  32'(pend),       32'(m_pend));
      check("model_ovf",   32'(overflow),   32'(m_ovf));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input logic v, input logic [3:0] c,
                            input logic [8:0] p, input logic o);
    check({name, "_valid"}, 32'(code_valid), 32'(v));
    check({name, "_code"},  32'(key_code),   32'(c));
    check({name, "_pend"},  32'(pend),       32'(p));
    check({name, "_ovf"},   32'(overflow),   32'(o));
  endtask

  initial begin
    n_checks = 0; n_fail = 0; cmp_en = 1'b0;
    rst = 1'b1; key_n = 9'h1FF; clr = 1'b0; code_ready = 1'b0;

    // Reset and idle
    tick(3);
    cmp_en = 1'b1;
    expect_out("reset", 1'b0, 4'd0, 9'h000, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      check("idle_valid", 32'(code_valid), 32'd0);
      check("idle_pend",  32'(pend),       32'd0);
    end

    // Single press of key 5 with consumer ready
    code_ready = 1'b1;
    key_n = ~9'h010;
    tick(5);
    check("k5_e5_pend", 32'(pend), 32'h000);
    tick(1);
    expect_out("k5_e6", 1'b0, 4'd0, 9'h010, 1'b0);
    tick(1);
    expect_out("k5_e7", 1'b1, 4'd5, 9'h010, 1'b0);
    tick(1);
    expect_out("k5_e8", 1'b0, 4'd5, 9'h000, 1'b0);
    tick(4);
    key_n = 9'h1FF;
    tick(12);
    expect_out("k5_rel", 1'b0, 4'd5, 9'h000, 1'b0);

    // Glitch shorter than debounce window
    key_n = ~9'h004;
    tick(3);
    key_n = 9'h1FF;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("glitch_valid", 32'(code_valid), 32'd0);
      check("glitch_pend",  32'(pend),       32'd0);
    end

    // Keys 2 and 9 together: 9 first, no preemption, then 2
    code_ready = 1'b0;
    key_n = ~9'h102;
    tick(7);
    expect_out("dual_pres", 1'b1, 4'd9, 9'h102, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("dual_hold_valid", 32'(code_valid), 32'd1);
      check("dual_hold_code",  32'(key_code),   32'd9);
    end
    code_ready = 1'b1;
    tick(1);
    expect_out("dual_acc9", 1'b0, 4'd9, 9'h002, 1'b0);
    tick(1);
    expect_out("dual_pres2", 1'b1, 4'd2, 9'h002, 1'b0);
    tick(1);
    expect_out("dual_acc2", 1'b0, 4'd2, 9'h000, 1'b0);
    code_ready = 1'b0;
    key_n = 9'h1FF;
    tick(12);

    // Overflow from re-press of key 3, then clear
    key_n = ~9'h004;
    tick(7);
    expect_out("ovf_first", 1'b1, 4'd3, 9'h004, 1'b0);
    key_n = 9'h1FF;
    tick(8);
    key_n = ~9'h004;
    tick(8);
    expect_out("ovf_set", 1'b1, 4'd3, 9'h004, 1'b1);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    expect_out("clr", 1'b0, 4'd3, 9'h000, 1'b0);
    tick(3);
    expect_out("clr_hold", 1'b0, 4'd3, 9'h000, 1'b0);
    key_n = 9'h1FF;
    tick(10);

    // Async reset while presenting key 7
    key_n = ~9'h040;
    tick(7);
    expect_out("k7_pres", 1'b1, 4'd7, 9'h040, 1'b0);
    rst = 1'b1;
    key_n = 9'h1FF;
    #1;
    check("arst_valid", 32'(code_valid), 32'd0);
    check("arst_code",  32'(key_code),   32'd0);
    check("arst_pend",  32'(pend),       32'd0);
    tick(2);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      check("post_rst_valid", 32'(code_valid), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
